// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//   Multi-cycle control sequencer for a single-port CPU datapath.
//   It steps each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> WB.
//   Instruction fetch and load/store share one req/ready memory port.
//   The sequencer keeps a retired-instruction counter and a stuck-memory
//   watchdog that halts the core with a sticky bus error.
//
//   Optional build macro:
//     HALT_ON_ILLEGAL_EN - undefined: an illegal opcode retires as a NOP.
//                          defined:   an illegal opcode halts the core in DECODE.
//
//   Parameters:
//     MAX_WAIT   number of cycles a request may wait for ready (0 = no watchdog)
//     CNT_W      width of instret
//     NOP_INSTR  value loaded into ir by reset
//
//   Ports:
//     clk           rising-edge clock
//     reset         synchronous, active-low reset
//     mem_rdata     memory read data, captured into ir when a fetch completes
//     mem_ready     memory accepts/completes the current request
//     dec_memtoreg  decoder MemtoReg (load or store)
//     dec_memwrite  decoder MemWrite (store)
//     dec_regwrite  decoder RegWrite
//     ir            latched instruction
//     mem_req       memory request
//     mem_we        memory write enable (store)
//     mem_dsel      address select: 0 = PC, 1 = ALU result
//     pc_we         PC update strobe
//     rf_we         register-file write strobe
//     state         current state (IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=7)
//     instret       retired-instruction count, wraps
//     bus_err       sticky watchdog error
//     halted        core stopped, cleared only by reset
// ---------------------------------------------------------------------------
module cpu_sequencer #(
   parameter int unsigned MAX_WAIT  = 16,
   parameter int unsigned CNT_W     = 32,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ready,
   input  logic             dec_memtoreg,
   input  logic             dec_memwrite,
   input  logic             dec_regwrite,
   output logic [31:0]      ir,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_dsel,
   output logic             pc_we,
   output logic             rf_we,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instret,
   output logic             bus_err,
   output logic             halted
);

   // Wait counter must be able to hold MAX_WAIT itself.
   localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd7
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [31:0]      ir_q;
   logic [CNT_W-1:0] instret_q;
   logic             bus_err_q;
   logic             halted_q;
   logic [WW-1:0]    wait_q;

   logic             illegal;
   logic             wait_cyc;
   logic             done;
   logic             wd_trip;

   // Opcode legality check on the latched instruction.
   always_comb begin
      illegal = 1'b1;
      case (ir_q[6:0])
         7'b0110111, 7'b0010111, 7'b1101111,
         7'b1100111, 7'b1100011, 7'b0000011,
         7'b0100011, 7'b0010011, 7'b0110011: illegal = 1'b0;
         default:                            illegal = 1'b1;
      endcase
   end

   assign wait_cyc = mem_req & ~mem_ready;
   assign done     = mem_req &  mem_ready;

   // Trip on the wait cycle that would bring the counter up to MAX_WAIT.
   assign wd_trip  = (MAX_WAIT != 0) && wait_cyc && (wait_q == WW'(MAX_WAIT - 1));

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (done) begin
               state_d = S_DECODE;
            end else if (wd_trip) begin
               state_d = S_HALT;
            end
         end
         S_DECODE: begin
`ifdef HALT_ON_ILLEGAL_EN
            state_d = illegal ? S_HALT : S_EXEC;
`else
            state_d = S_EXEC;
`endif
         end
         S_EXEC: begin
            state_d = (dec_memtoreg & ~illegal) ? S_MEM : S_WB;
         end
         S_MEM: begin
            if (done) begin
               state_d = S_WB;
            end else if (wd_trip) begin
               state_d = S_HALT;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            // Unused encoding recovers through IDLE.
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Moore output decode
   // ------------------------------------------------------------------------
   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_dsel = 1'b0;
      pc_we    = 1'b0;
      rf_we    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_dsel = 1'b1;
            mem_we   = dec_memwrite;
         end
         S_WB: begin
            pc_we = 1'b1;
            rf_we = dec_regwrite & ~illegal;
         end
         default: begin
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Instruction register, retire counter, watchdog and status flags
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         ir_q      <= NOP_INSTR;
         instret_q <= '0;
         bus_err_q <= 1'b0;
         halted_q  <= 1'b0;
         wait_q    <= '0;
      end else begin
         if ((state_q == S_FETCH) && done) begin
            ir_q <= mem_rdata;
         end
         if (state_q == S_WB) begin
            instret_q <= instret_q + CNT_W'(1);
         end
         if (wd_trip) begin
            bus_err_q <= 1'b1;
         end
         if (state_d == S_HALT) begin
            halted_q <= 1'b1;
         end
         if (done) begin
            wait_q <= '0;
         end else if (wait_cyc && (MAX_WAIT != 0)) begin
            wait_q <= wait_q + WW'(1);
         end
      end
   end

   assign ir      = ir_q;
   assign state   = state_q;
   assign instret = instret_q;
   assign bus_err = bus_err_q;
   assign halted  = halted_q;

endmodule
